// File: rtl/parking_pkg.sv
// parking_pkg: shared gate states, lane ids and default lot constants
package parking_pkg;

    typedef enum logic [1:0] {IDLE, OPEN_IN, OPEN_OUT, GUARD} gate_state_t;

    typedef enum logic {ENTRY, EXIT} lane_t;

    localparam int PARK_CAPACITY    = 16;
    localparam int PARK_OPEN_CYCLES = 8;

endpackage

// File: rtl/park_rr_arb2.sv
// park_rr_arb2: two-lane round-robin pick with a last-served register
module park_rr_arb2
    import parking_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] elig,
    input  logic       update,
    output logic [1:0] pick
);

    lane_t last_q, last_d;

    // On a tie serve the lane that did not win last; remember the winner on update
    always_comb begin
        pick   = (&elig) ? ((last_q == EXIT) ? 2'b01 : 2'b10) : elig;
        last_d = (update && |pick) ? (pick[1] ? EXIT : ENTRY) : last_q;
    end

    // Last-served register; EXIT after reset so the entrance wins the first tie
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) last_q <= EXIT;
        else          last_q <= last_d;
    end

endmodule

// File: rtl/parking_gate_arbiter.sv
// parking_gate_arbiter: shares one barrier gate between entry and exit lanes and tracks occupancy
module parking_gate_arbiter
    import parking_pkg::*;
#(
    parameter int CAPACITY    = PARK_CAPACITY,
    parameter int OPEN_CYCLES = PARK_OPEN_CYCLES,
    parameter int COUNT_W     = 5
)(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               entry_req,
    input  logic               exit_req,
    input  logic               car_passed,
    output logic               entry_grant,
    output logic               exit_grant,
    output logic               gate_open,
    output logic               timeout,
    output logic [COUNT_W-1:0] occupancy,
    output logic               full,
    output logic               empty
);

    localparam int TW = $clog2(OPEN_CYCLES + 1);

    gate_state_t        state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [COUNT_W-1:0] occ_q, occ_d;
    logic               entry_grant_q, entry_grant_d;
    logic               exit_grant_q, exit_grant_d;
    logic               gate_open_q, gate_open_d;
    logic               timeout_q, timeout_d;
    logic [1:0]         elig, pick;

    assign full        = occ_q == COUNT_W'(CAPACITY);
    assign empty       = occ_q == '0;
    assign elig        = {exit_req && !empty, entry_req && !full};
    assign occupancy   = occ_q;
    assign entry_grant = entry_grant_q;
    assign exit_grant  = exit_grant_q;
    assign gate_open   = gate_open_q;
    assign timeout     = timeout_q;

    park_rr_arb2 u_arb (
        .clk    (clk),
        .reset_n(reset_n),
        .elig   (elig),
        .update (state_q == IDLE),
        .pick   (pick)
    );

    // Gate FSM: grant one lane, hold the gate until a pass or expiry, then one closed guard cycle
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        occ_d         = occ_q;
        entry_grant_d = 1'b0;
        exit_grant_d  = 1'b0;
        gate_open_d   = 1'b0;
        timeout_d     = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d       = '0;
                state_d       = pick[0] ? OPEN_IN : pick[1] ? OPEN_OUT : IDLE;
                entry_grant_d = pick[0];
                exit_grant_d  = pick[1];
                gate_open_d   = |pick;
            end
            OPEN_IN, OPEN_OUT: begin
                timer_d     = timer_q + 1'b1;
                gate_open_d = 1'b1;
                if (car_passed) begin
                    state_d     = GUARD;
                    gate_open_d = 1'b0;
                    if (state_q == OPEN_IN && !full)
                        occ_d = occ_q + 1'b1;
                    else if (state_q == OPEN_OUT && !empty)
                        occ_d = occ_q - 1'b1;
                end else if (timer_q == TW'(OPEN_CYCLES - 1)) begin
                    state_d     = GUARD;
                    gate_open_d = 1'b0;
                    timeout_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, timer, occupancy and registered outputs; reset closes the gate at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            occ_q         <= '0;
            entry_grant_q <= 1'b0;
            exit_grant_q  <= 1'b0;
            gate_open_q   <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            occ_q         <= occ_d;
            entry_grant_q <= entry_grant_d;
            exit_grant_q  <= exit_grant_d;
            gate_open_q   <= gate_open_d;
            timeout_q     <= timeout_d;
        end
    end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// tb_parking_gate_arbiter: directed self-checking bench for the shared parking gate
module tb_parking_gate_arbiter;

    logic       clk = 1'b0;
    logic       reset_n, entry_req, exit_req, car_passed;
    logic       entry_grant, exit_grant, gate_open, timeout, full, empty;
    logic [4:0] occupancy;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    parking_gate_arbiter #(.CAPACITY(16), .OPEN_CYCLES(8), .COUNT_W(5)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .entry_req  (entry_req),
        .exit_req   (exit_req),
        .car_passed (car_passed),
        .entry_grant(entry_grant),
        .exit_grant (exit_grant),
        .gate_open  (gate_open),
        .timeout    (timeout),
        .occupancy  (occupancy),
        .full       (full),
        .empty      (empty)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // lane: 0 entry, 1 exit, -1 none within the budget
    task automatic wait_grant(output int lane, output int waited);
        lane   = -1;
        waited = 0;
        for (int i = 1; i <= 20 && lane < 0; i++) begin
            tick();
            waited = i;
            if (entry_grant) lane = 0;
            else if (exit_grant) lane = 1;
        end
        if (lane < 0) check("grant_wait", 0, 1);
    endtask

    // Called in the grant cycle; keeps the gate open n cycles, then the car passes
    task automatic do_pass(input int n);
        repeat (n - 1) tick();
        car_passed = 1'b1;
        tick();
        car_passed = 1'b0;
    endtask

    task automatic serve(input int exp_lane, input int n, input string tag);
        int lane, w;
        wait_grant(lane, w);
        check(tag, lane, exp_lane);
        do_pass(n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lane, w, cnt, tos, g;
        reset_n    = 1'b0;
        entry_req  = 1'b0;
        exit_req   = 1'b0;
        car_passed = 1'b0;
        tick();
        tick();
        check("rst_occ", occupancy, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_gate", gate_open, 0);
        check("rst_grants", {entry_grant, exit_grant}, 0);
        check("rst_timeout", timeout, 0);
        reset_n = 1'b1;
        tick();

        // Single entry, car passes after 3 open cycles
        entry_req = 1'b1;
        wait_grant(lane, w);
        check("t1_lane", lane, 0);
        check("t1_latency", w, 1);
        check("t1_gate0", gate_open, 1);
        entry_req = 1'b0;
        tick();
        check("t1_grant_pulse", entry_grant, 0);
        check("t1_gate1", gate_open, 1);
        tick();
        check("t1_gate2", gate_open, 1);
        car_passed = 1'b1;
        tick();
        car_passed = 1'b0;
        check("t1_gate_closed", gate_open, 0);
        check("t1_occ", occupancy, 1);
        check("t1_empty", empty, 0);
        check("t1_full", full, 0);
        tick();

        // Bring occupancy to 5 with the exit lane served last
        entry_req = 1'b1;
        repeat (5) serve(0, 1, "prep_in");
        entry_req = 1'b0;
        exit_req  = 1'b1;
        serve(1, 1, "prep_out");
        exit_req = 1'b0;
        check("prep_occ", occupancy, 5);

        // Both lanes held: strict alternation starting with entry
        entry_req = 1'b1;
        exit_req  = 1'b1;
        serve(0, 1, "alt0");
        serve(1, 2, "alt1");
        serve(0, 1, "alt2");
        serve(1, 3, "alt3");
        entry_req = 1'b0;
        exit_req  = 1'b0;
        check("alt_occ", occupancy, 5);
        tick();
        tick();

        // Grant with no car: 8 open cycles then timeout
        entry_req = 1'b1;
        wait_grant(lane, w);
        check("to_lane", lane, 0);
        entry_req = 1'b0;
        cnt = 0;
        tos = 0;
        for (int i = 0; i < 20 && gate_open; i++) begin
            cnt++;
            tos += int'(timeout);
            tick();
        end
        check("to_open_cycles", cnt, 8);
        check("to_early_timeout", tos, 0);
        check("to_pulse", timeout, 1);
        check("to_guard_gate", gate_open, 0);
        check("to_occ", occupancy, 5);
        tick();
        check("to_pulse_end", timeout, 0);
        check("to_idle_gate", gate_open, 0);

        // Fill the lot, entry blocked while full
        entry_req = 1'b1;
        repeat (11) serve(0, 1, "fill");
        check("fill_occ", occupancy, 16);
        check("fill_full", full, 1);
        g = 0;
        repeat (6) begin
            tick();
            g += int'(entry_grant | exit_grant);
        end
        check("full_no_grant", g, 0);
        exit_req = 1'b1;
        wait_grant(lane, w);
        check("full_exit_lane", lane, 1);
        exit_req = 1'b0;
        do_pass(2);
        check("full_exit_occ", occupancy, 15);
        check("full_cleared", full, 0);
        wait_grant(lane, w);
        check("pending_entry_lane", lane, 0);
        check("pending_entry_wait", w, 2);
        do_pass(1);
        entry_req = 1'b0;
        check("refill_occ", occupancy, 16);

        // Drain to empty, exit blocked while empty, stray pass ignored
        exit_req = 1'b1;
        repeat (16) serve(1, 1, "drain");
        check("drain_occ", occupancy, 0);
        check("drain_empty", empty, 1);
        g = 0;
        repeat (6) begin
            tick();
            g += int'(entry_grant | exit_grant);
        end
        check("empty_no_grant", g, 0);
        exit_req   = 1'b0;
        car_passed = 1'b1;
        tick();
        car_passed = 1'b0;
        tick();
        check("stray_pass_occ", occupancy, 0);
        check("stray_pass_gate", gate_open, 0);

        // Pass on the expiry cycle wins over timeout
        entry_req = 1'b1;
        wait_grant(lane, w);
        check("tie_lane", lane, 0);
        entry_req = 1'b0;
        repeat (7) tick();
        check("tie_last_open", gate_open, 1);
        car_passed = 1'b1;
        tick();
        car_passed = 1'b0;
        check("tie_occ", occupancy, 1);
        check("tie_timeout", timeout, 0);
        check("tie_gate", gate_open, 0);
        tick();

        // Reset mid-grant closes the gate at once and discards the in-flight car
        entry_req = 1'b1;
        wait_grant(lane, w);
        check("mid_lane", lane, 0);
        tick();
        check("mid_gate_open", gate_open, 1);
        car_passed = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_gate", gate_open, 0);
        check("mid_rst_occ", occupancy, 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_full", full, 0);
        check("mid_rst_grants", {entry_grant, exit_grant}, 0);
        check("mid_rst_timeout", timeout, 0);
        car_passed = 1'b0;
        entry_req  = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        check("post_rst_occ", occupancy, 0);
        check("post_rst_gate", gate_open, 0);
        entry_req = 1'b1;
        wait_grant(lane, w);
        check("post_rst_lane", lane, 0);
        check("post_rst_latency", w, 1);
        entry_req = 1'b0;
        do_pass(1);
        check("post_rst_occ_inc", occupancy, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
